multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Multi-cycle control FSM that drives every datapath control input of the Processor_Integration_5 datapath: the signals the integration bench currently toggles by hand.
- Decodes the opcode in IR[15:12], sequences fetch/decode/execute/memory/writeback, and reads back isZero.
- Handshakes with instruction/data memory through Mem_Read/Mwrite and Mem_Ready.

Parameters:
- OPW, 4, opcode field width (IR[15:12]).
- ALU_ADD, 3'd1, ALUcontrol code for add; also the idle default. Other codes: AND=0, SUB=2, OR=3, pass-A=6, pass-B=7.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- IR  in  16  instruction register contents; [15:12] opcode, [11:10] rd.
- isZero  in  1  registered zero flag from datapath.
- Mem_Ready  in  1  memory completes the current read/write this cycle.
- Mem_Read  out  1  memory read request (fetch or load).
- IR_Write, PCWrite, Awrite, Bwrite, ALUOutWrite, reg_write, iszero_write, Mwrite  out  1 each  datapath write enables.
- Asel, Bsel, ItypeSel  out  1 each  operand selects: Asel=1 regfile, 0 IR imm; Bsel=1 imm; ItypeSel=1 sign-ext IR[7:0], 0 IR[7:0]<<8.
- ALUcontrol  out  3  ALU operation.
- destData  out  3  writeback source: 0 ALUOut, 1 memory data, 5 PC.
- destAddr  out  2  writeback register.
- jControl  out  2  next-PC source: 0 PC+1, 1 PC+IR offset, 2 {PC[15:12],IR[11:0]}, 3 ALUOut.
- Halted  out  1  high in HALT state.
- Illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Outputs are combinational from the state register. In FETCH/MEM_RD/MEM_WR they also depend on Mem_Ready.
- Default output values (also the values during reset): all enables 0, Mem_Read 0, Halted 0, Illegal 0, ALUcontrol=1, Asel=1, Bsel=0, ItypeSel=0, destData=0, destAddr=0, jControl=0.
- Reset_n low: state goes to FETCH immediately (async). Takes effect mid-instruction, including mid-store: Mwrite drops in the same delta.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LUI, 6 LW, 7 SW, 8 BEQZ, 9 J, A JAL, B JR, F HALT; C/D/E illegal.
- Every state not listed below returns to FETCH on the next cycle.
- FETCH:
  - Mem_Read=1.
  - If Mem_Ready: IR_Write=1, PCWrite=1, jControl=0, go to DECODE.
  - Otherwise hold in FETCH with all enables 0.
- DECODE: Awrite=1, Bwrite=1, Asel=1. Bsel=1 for opcodes 4–7; ItypeSel=1 except LUI (0). Next state by opcode:
  - R-type (0–3) -> EXEC_R.
  - 4/5 -> EXEC_I.
  - 6/7 -> MEM_ADDR.
  - 8 -> BRANCH.
  - 9 -> JUMP.
  - A -> JAL_LINK.
  - B -> EXEC_JR.
  - F -> HALT.
  - C/D/E: Illegal=1, -> FETCH.
- EXEC_R: ALUOutWrite=1, iszero_write=1, ALUcontrol by opcode (ADD 1, SUB 2, AND 0, OR 3). -> WB.
- EXEC_I: ALUOutWrite=1, iszero_write=1, Bsel=1. ALUcontrol=1, ItypeSel=1 for ADDI; ALUcontrol=7, ItypeSel=0 for LUI. -> WB.
- WB: reg_write=1, destData=0, destAddr=IR[11:10]. -> FETCH.
- MEM_ADDR: ALUOutWrite=1, ALUcontrol=1, Bsel=1, ItypeSel=1. -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: Mem_Read=1; on Mem_Ready -> MEM_WB, else wait.
- MEM_WB: reg_write=1, destData=1, destAddr=IR[11:10].
- MEM_WR: Mwrite=1 held until Mem_Ready sampled high; then -> FETCH.
- BRANCH: PCWrite=isZero, jControl=1.
- JUMP: PCWrite=1, jControl=2.
- JAL_LINK: reg_write=1, destData=5, destAddr=3. PC already holds the return address. -> JUMP.
- EXEC_JR: ALUOutWrite=1, ALUcontrol=6. -> JR_PC.
- JR_PC: PCWrite=1, jControl=3.
- HALT: Halted=1, all enables 0. Held until reset; Mem_Ready is ignored.
- Latency with Mem_Ready tied high (cycles): R/I-type 4, LW 5, SW 4, BEQZ 3, J 3, JAL 4, JR 4, HALT 2 to reach.
- No enable asserted in a wait cycle, so stalls never double-increment the PC.
- Mem_Ready arriving in the first cycle of a wait state completes it with zero wait.

Test Plan:
- Reset_n low then high, Mem_Ready=1, IR=0x1400 (SUB rd=1). Required sequence: FETCH (IR_Write, PCWrite, jControl=0); DECODE (Awrite, Bwrite); EXEC_R (ALUOutWrite, ALUcontrol=2, iszero_write); WB (reg_write, destAddr=1, destData=0).
- Mem_Ready=0 for 3 cycles in FETCH, then 1. Required: Mem_Read high all 4 cycles; IR_Write/PCWrite high only in the 4th; PC advances by exactly 1.
- IR=0x7205 (SW). MEM_ADDR shows ALUcontrol=1, Bsel=1, ItypeSel=1. Mwrite held high for 2 cycles of Mem_Ready=0 and the completing cycle. Pulling Reset_n low during a repeat run: Mwrite drops immediately and the state is FETCH.
- BEQZ IR=0x8002: with isZero=1, PCWrite=1, jControl=1 in BRANCH (datapath PC 1 -> 3); with isZero=0, PCWrite=0.
- JAL IR=0xA002 with PC=0xABCD. Required: JAL_LINK reg_write=1, destData=5, destAddr=3; then JUMP jControl=2, giving PC=0xA002.
- IR=0xD000 -> Illegal pulses once in DECODE, next state FETCH. IR=0xF000 -> Halted=1 and stays there with Mem_Ready toggling, until Reset_n is asserted.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the Processor_Integration_5 datapath.
// Decodes IR[15:12], sequences fetch/decode/execute/memory/writeback and
// drives every datapath write enable, operand select and ALU code.
module multicycle_control_unit #(
   parameter int          OPW     = 4,
   parameter logic [2:0]  ALU_ADD = 3'd1
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic [15:0] IR,
   input  logic        isZero,
   input  logic        Mem_Ready,
   output logic        Mem_Read,
   output logic        IR_Write,
   output logic        PCWrite,
   output logic        Awrite,
   output logic        Bwrite,
   output logic        ALUOutWrite,
   output logic        reg_write,
   output logic        iszero_write,
   output logic        Mwrite,
   output logic        Asel,
   output logic        Bsel,
   output logic        ItypeSel,
   output logic [2:0]  ALUcontrol,
   output logic [2:0]  destData,
   output logic [1:0]  destAddr,
   output logic [1:0]  jControl,
   output logic        Halted,
   output logic        Illegal
);

   localparam logic [2:0] ALU_AND   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd2;
   localparam logic [2:0] ALU_OR    = 3'd3;
   localparam logic [2:0] ALU_PASSA = 3'd6;
   localparam logic [2:0] ALU_PASSB = 3'd7;

   localparam logic [OPW-1:0] OP_ADD  = OPW'(4'h0);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(4'h1);
   localparam logic [OPW-1:0] OP_AND  = OPW'(4'h2);
   localparam logic [OPW-1:0] OP_OR   = OPW'(4'h3);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(4'h4);
   localparam logic [OPW-1:0] OP_LUI  = OPW'(4'h5);
   localparam logic [OPW-1:0] OP_LW   = OPW'(4'h6);
   localparam logic [OPW-1:0] OP_SW   = OPW'(4'h7);
   localparam logic [OPW-1:0] OP_BEQZ = OPW'(4'h8);
   localparam logic [OPW-1:0] OP_J    = OPW'(4'h9);
   localparam logic [OPW-1:0] OP_JAL  = OPW'(4'hA);
   localparam logic [OPW-1:0] OP_JR   = OPW'(4'hB);
   localparam logic [OPW-1:0] OP_HALT = OPW'(4'hF);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB, S_MEM_ADDR, S_MEM_RD,
      S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL_LINK, S_EXEC_JR, S_JR_PC,
      S_HALT
   } state_t;

   state_t          state_q, state_d;
   logic [OPW-1:0]  opcode;

   assign opcode = IR[15 -: OPW];

   // State register; reset forces FETCH asynchronously
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) state_q <= S_FETCH;
      else          state_q <= state_d;
   end

   // Next-state selection
   always_comb begin
      state_d = S_FETCH;
      unique case (state_q)
         S_FETCH:    state_d = Mem_Ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_EXEC_R;
               OP_ADDI, OP_LUI:               state_d = S_EXEC_I;
               OP_LW, OP_SW:                  state_d = S_MEM_ADDR;
               OP_BEQZ:                       state_d = S_BRANCH;
               OP_J:                          state_d = S_JUMP;
               OP_JAL:                        state_d = S_JAL_LINK;
               OP_JR:                         state_d = S_EXEC_JR;
               OP_HALT:                       state_d = S_HALT;
               default:                       state_d = S_FETCH;
            endcase
         end
         S_EXEC_R,
         S_EXEC_I:   state_d = S_WB;
         S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   state_d = Mem_Ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR:   state_d = Mem_Ready ? S_FETCH : S_MEM_WR;
         S_JAL_LINK: state_d = S_JUMP;
         S_EXEC_JR:  state_d = S_JR_PC;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_FETCH;
      endcase
   end

   // Control outputs decoded from state; held at defaults while reset is low
   always_comb begin
      Mem_Read     = 1'b0;
      IR_Write     = 1'b0;
      PCWrite      = 1'b0;
      Awrite       = 1'b0;
      Bwrite       = 1'b0;
      ALUOutWrite  = 1'b0;
      reg_write    = 1'b0;
      iszero_write = 1'b0;
      Mwrite       = 1'b0;
      Asel         = 1'b1;
      Bsel         = 1'b0;
      ItypeSel     = 1'b0;
      ALUcontrol   = ALU_ADD;
      destData     = 3'd0;
      destAddr     = 2'd0;
      jControl     = 2'd0;
      Halted       = 1'b0;
      Illegal      = 1'b0;
      if (Reset_n) begin
         unique case (state_q)
            S_FETCH: begin
               Mem_Read = 1'b1;
               IR_Write = Mem_Ready;
               PCWrite  = Mem_Ready;
            end
            S_DECODE: begin
               Awrite   = 1'b1;
               Bwrite   = 1'b1;
               Bsel     = (opcode == OP_ADDI) || (opcode == OP_LUI) ||
                          (opcode == OP_LW)   || (opcode == OP_SW);
               ItypeSel = (opcode != OP_LUI);
               Illegal  = (opcode == OPW'(4'hC)) || (opcode == OPW'(4'hD)) ||
                          (opcode == OPW'(4'hE));
            end
            S_EXEC_R: begin
               ALUOutWrite  = 1'b1;
               iszero_write = 1'b1;
               case (opcode)
                  OP_SUB:  ALUcontrol = ALU_SUB;
                  OP_AND:  ALUcontrol = ALU_AND;
                  OP_OR:   ALUcontrol = ALU_OR;
                  default: ALUcontrol = ALU_ADD;
               endcase
            end
            S_EXEC_I: begin
               ALUOutWrite  = 1'b1;
               iszero_write = 1'b1;
               Bsel         = 1'b1;
               ALUcontrol   = (opcode == OP_LUI) ? ALU_PASSB : ALU_ADD;
               ItypeSel     = (opcode != OP_LUI);
            end
            S_WB: begin
               reg_write = 1'b1;
               destAddr  = IR[11:10];
            end
            S_MEM_ADDR: begin
               ALUOutWrite = 1'b1;
               Bsel        = 1'b1;
               ItypeSel    = 1'b1;
            end
            S_MEM_RD:   Mem_Read = 1'b1;
            S_MEM_WB: begin
               reg_write = 1'b1;
               destData  = 3'd1;
               destAddr  = IR[11:10];
            end
            S_MEM_WR:   Mwrite = 1'b1;
            S_BRANCH: begin
               PCWrite  = isZero;
               jControl = 2'd1;
            end
            S_JUMP: begin
               PCWrite  = 1'b1;
               jControl = 2'd2;
            end
            // PC was already advanced in FETCH, so it is the return address
            S_JAL_LINK: begin
               reg_write = 1'b1;
               destData  = 3'd5;
               destAddr  = 2'd3;
            end
            S_EXEC_JR: begin
               ALUOutWrite = 1'b1;
               ALUcontrol  = ALU_PASSA;
            end
            S_JR_PC: begin
               PCWrite  = 1'b1;
               jControl = 2'd3;
            end
            S_HALT:     Halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule
